mem_stream_merger: RTL and testbench

- Downstream consumer of the per-event memory-bank priority selection.
- After a start pulse, drains up to NBANK memory banks in fixed priority order (bank 0 highest), skipping empty banks.
- Issues registered reads and merges the banks into one valid/ready output stream.
- Holds an internal credit-controlled output FIFO so downstream backpressure never loses in-flight read data.

---
 rtl/mem_stream_merger_pkg.sv | 36 +++
 rtl/mem_stream_merger_if.sv | 28 ++
 rtl/mem_stream_merger_out_fifo.sv | 49 ++++
 rtl/mem_stream_merger.sv | 127 ++++++++++++
 tb/tb_mem_stream_merger.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stream_merger_pkg.sv
// Shared constants, types and helpers for the memory-bank stream merger.
// BANK_TAG_EN widens the merged word by a 4-bit source bank tag.
package mem_stream_merger_pkg;
  localparam int NBANK      = 12;
  localparam int DATA_W     = 36;
  localparam int ADDR_W     = 6;
  localparam int CNT_W      = ADDR_W + 1;
  localparam int BANK_IDX_W = 4;
  localparam int RD_LAT     = 2;
  localparam int FIFO_D     = 4;
`ifdef BANK_TAG_EN
  localparam int TAG_W      = 4;
`else
  localparam int TAG_W      = 0;
`endif
  localparam int OUT_W      = DATA_W + TAG_W;

  typedef logic [BANK_IDX_W-1:0] bank_idx_t;
  typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;

  // Bank 0 has the highest priority; an empty mask selects bank 0.
  function automatic bank_idx_t lowest_bank(input logic [NBANK-1:0] m);
    bank_idx_t b;
    b = '0;
    for (int k = NBANK - 1; k >= 0; k--) begin
      if (m[k]) b = BANK_IDX_W'(k);
    end
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] lim;
    lim = CNT_W'(1 << ADDR_W);
    return (c > lim) ? lim : c;
  endfunction
endpackage

// File: rtl/mem_stream_merger_if.sv
// Bus bundle of the stream merger: start/counts in, bank reads out,
// registered read data in, merged valid/ready stream out, status out.
interface mem_stream_merger_if;
  import mem_stream_merger_pkg::*;

  logic                    start;
  logic [NBANK*CNT_W-1:0]  nent_i;
  logic                    rd_en;
  bank_idx_t               rd_bank;
  logic [ADDR_W-1:0]       rd_addr;
  logic [NBANK*DATA_W-1:0] rd_data_i;
  logic [OUT_W-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    done;

  // A word transfers on a rising edge where out_valid and out_ready are both
  // high; while out_valid is high and out_ready low, out_data holds steady.
  modport master (
    input  start, nent_i, rd_data_i, out_ready,
    output rd_en, rd_bank, rd_addr, out_data, out_valid, busy, done
  );
  modport slave (
    output start, nent_i, rd_data_i, out_ready,
    input  rd_en, rd_bank, rd_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/mem_stream_merger_out_fifo.sv
// First-word-fall-through output buffer; head word and valid come straight
// from registers, and count feeds the read-credit calculation.
module merger_out_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         pop,
  output logic [W-1:0]                 rd_data,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && valid;
  assign valid   = (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_en, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mem_stream_merger.sv
// Drains non-empty memory banks in priority order into one valid/ready stream.
// BANK_TAG_EN appends the source bank index above the data bits.
module mem_stream_merger
  import mem_stream_merger_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  mem_stream_merger_if.master bus
);
  localparam int FC_W = $clog2(FIFO_D + 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt_q [NBANK];
  logic [NBANK-1:0]  mask, load_mask, mask_clr;
  bank_idx_t         cur_bank;
  logic [ADDR_W-1:0] addr;
  logic [RD_LAT-1:0] pv;
  bank_idx_t         pb [RD_LAT];
  logic [FC_W-1:0]   fifo_count;
  logic              rd_fire, last_rd, credit_ok, pop, fifo_valid, done_d, done_q;
  logic [DATA_W-1:0] cap_data;
  logic [OUT_W-1:0]  wr_word, fifo_word;
  int                inflight;

  always_comb begin
    load_mask = '0;
    for (int k = 0; k < NBANK; k++) load_mask[k] = |bus.nent_i[k*CNT_W +: CNT_W];
  end

  // Credit covers both FIFO occupancy and reads still travelling through memory.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + (pv[i] ? 1 : 0);
    credit_ok = (int'(fifo_count) + inflight) < FIFO_D;
  end

  assign pop      = fifo_valid && bus.out_ready;
  assign mask_clr = mask & ~(NBANK'(1) << cur_bank);
  assign last_rd  = ({1'b0, addr} == cnt_q[cur_bank] - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    rd_fire = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_d = LOAD;
      LOAD:  state_d = (load_mask == '0) ? DRAIN : READ;
      READ: begin
        rd_fire = credit_ok;
        if (credit_ok && last_rd && mask_clr == '0) state_d = DRAIN;
      end
      DRAIN: begin
        // Finish in the cycle the last word leaves, so done lands right after.
        if (inflight == 0 && (fifo_count == '0 || (fifo_count == FC_W'(1) && pop))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NBANK; k++) cnt_q[k] <= '0;
      mask     <= '0;
      cur_bank <= '0;
      addr     <= '0;
      done_q   <= 1'b0;
      pv       <= '0;
      for (int i = 0; i < RD_LAT; i++) pb[i] <= '0;
    end else begin
      done_q <= done_d;
      if (state == LOAD) begin
        for (int k = 0; k < NBANK; k++) cnt_q[k] <= sat_count(bus.nent_i[k*CNT_W +: CNT_W]);
        mask     <= load_mask;
        cur_bank <= lowest_bank(load_mask);
        addr     <= '0;
      end else if (rd_fire) begin
        if (last_rd) begin
          mask     <= mask_clr;
          cur_bank <= lowest_bank(mask_clr);
          addr     <= '0;
        end else begin
          addr <= addr + 1'b1;
        end
      end
      pv[0] <= rd_fire;
      pb[0] <= cur_bank;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end

  assign cap_data = bus.rd_data_i[DATA_W*int'(pb[RD_LAT-1]) +: DATA_W];
`ifdef BANK_TAG_EN
  assign wr_word = {pb[RD_LAT-1], cap_data};
`else
  assign wr_word = cap_data;
`endif

  merger_out_fifo #(.W(OUT_W), .DEPTH(FIFO_D)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pv[RD_LAT-1]),
    .wr_data (wr_word),
    .pop     (pop),
    .rd_data (fifo_word),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

  assign bus.rd_en     = rd_fire;
  assign bus.rd_bank   = cur_bank;
  assign bus.rd_addr   = addr;
  assign bus.out_data  = fifo_word;
  assign bus.out_valid = fifo_valid;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_mem_stream_merger.sv
// Bench for mem_stream_merger: bank memory responder, queue-based reference
// stream, table of directed events, reset/restart corner cases, random events.
module tb_mem_stream_merger;
  import mem_stream_merger_pkg::*;

  localparam int NW     = NBANK * CNT_W;
  localparam int SALT_W = DATA_W - BANK_IDX_W - ADDR_W;
  typedef logic [NW-1:0] nent_t;
  typedef struct {
    nent_t nent;
    int    rmode;
    int    exp_words;
    int    exp_first;
    int    exp_done;
    int    restart_at;
    string name;
  } vec_t;
  typedef struct packed {
    logic              en;
    bank_idx_t         b;
    logic [ADDR_W-1:0] a;
  } rd_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stream_merger_if bus();
  mem_stream_merger dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass = 0;
  int rdy_mode = 0;
  logic [SALT_W-1:0] salt = '0;
  logic [OUT_W-1:0] exp_q[$];
  int issued, popped, max_out, first_valid, done_cnt, done_lat, busy_cnt, start_cyc;
  logic stall_q = 1'b0;
  logic [OUT_W-1:0] stall_data;
  rd_t h0 = '0;
  rd_t h1 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input int b, input int a, input logic [SALT_W-1:0] s);
    return {BANK_IDX_W'(b), ADDR_W'(a), s};
  endfunction

  function automatic logic [OUT_W-1:0] exp_word(input int b, input int a, input logic [SALT_W-1:0] s);
`ifdef BANK_TAG_EN
    return {BANK_IDX_W'(b), mem_word(b, a, s)};
`else
    return mem_word(b, a, s);
`endif
  endfunction

  function automatic nent_t put(input nent_t v, input int b, input int c);
    v[b*CNT_W +: CNT_W] = CNT_W'(c);
    return v;
  endfunction

  function automatic nent_t rand_nent();
    nent_t v;
    for (int k = 0; k < NBANK; k++) v[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 127));
    return v;
  endfunction

  function automatic vec_t mkvec(input nent_t n, input int rm, input int w, input int f,
                                 input int d, input int rs, input string nm);
    vec_t v;
    v.nent = n; v.rmode = rm; v.exp_words = w; v.exp_first = f;
    v.exp_done = d; v.restart_at = rs; v.name = nm;
    return v;
  endfunction

  // Reference stream: banks in index order, each from address 0, count capped at 2^ADDR_W.
  task automatic build_model(input nent_t n);
    int c;
    exp_q.delete();
    for (int b = 0; b < NBANK; b++) begin
      c = int'(n[b*CNT_W +: CNT_W]);
      if (c > (1 << ADDR_W)) c = 1 << ADDR_W;
      for (int a = 0; a < c; a++) exp_q.push_back(exp_word(b, a, salt));
    end
  endtask

  task automatic reset_stats();
    issued = 0; popped = 0; max_out = 0; first_valid = -1;
    done_cnt = 0; done_lat = -1; busy_cnt = 0; start_cyc = cyc;
  endtask

  // bank memories: data for a read appears RD_LAT cycles after its rd_en
  always @(negedge clk) begin
    for (int k = 0; k < NBANK; k++)
      bus.rd_data_i[k*DATA_W +: DATA_W] = h1.en ? mem_word(k, int'(h1.a), salt)
                                                : DATA_W'({$urandom(), $urandom()});
    h1 = h0;
    h0 = {bus.rd_en, bus.rd_bank, bus.rd_addr};
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 4) == 0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) check("hold_while_stalled", {bus.out_valid, bus.out_data}, {1'b1, stall_data});
      if (bus.rd_en) issued++;
      if (bus.busy) busy_cnt++;
      if (bus.out_valid && first_valid < 0) first_valid = cyc - start_cyc;
      if (bus.out_valid && bus.out_ready) begin
        popped++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", bus.out_data);
        end else begin
          check("out_word", bus.out_data, exp_q.pop_front());
        end
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (bus.done) begin
        done_cnt++;
        done_lat = cyc - start_cyc;
      end
      stall_q    = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
    end
  end

  task automatic run_event(input vec_t v);
    salt = SALT_W'($urandom());
    build_model(v.nent);
    @(posedge clk); #1;
    rdy_mode = v.rmode;
    bus.nent_i = v.nent;
    bus.start = 1'b1;
    reset_stats();
    for (int t = 1; t < 4000 && done_cnt == 0; t++) begin
      @(posedge clk); #1;
      bus.start = (t == v.restart_at);
      if (t >= 2) bus.nent_i = rand_nent();
    end
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check({v.name, " done_pulses"}, done_cnt, 1);
    check({v.name, " words"}, popped, v.exp_words);
    check({v.name, " leftover_expected"}, exp_q.size(), 0);
    check({v.name, " first_valid_lat"}, first_valid, v.exp_first);
    if (v.exp_done >= 0) begin
      check({v.name, " done_lat"}, done_lat, v.exp_done);
      check({v.name, " busy_cycles"}, busy_cnt, v.exp_done - 1);
    end
    check({v.name, " outstanding_le_fifo_d"}, max_out <= FIFO_D, 1);
    check({v.name, " idle_after"}, {bus.busy, bus.out_valid}, 0);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[7];

  initial begin
    tbl[0] = mkvec(put(put('0, 0, 3), 5, 2), 0, 5, 5, 10, -1, "b0x3_b5x2");
    tbl[1] = mkvec('0, 0, 0, -1, 3, -1, "all_empty");
    tbl[2] = mkvec(put('0, 11, 64), 1, 64, 5, -1, -1, "b11x64_throttled");
    tbl[3] = mkvec(put('0, 2, 127), 0, 64, 5, 69, -1, "b2_saturate");
    tbl[4] = mkvec(put(put(put('0, 0, 1), 2, 2), 11, 1), 0, 4, 5, 9, -1, "sparse_banks");
    tbl[5] = mkvec(put('0, 3, 10), 0, 10, 5, 15, 5, "start_during_read");
    tbl[6] = mkvec(put(put('0, 7, 70), 8, 1), 2, 65, 5, -1, -1, "random_ready");

    bus.start = 1'b0;
    bus.nent_i = '0;
    reset_stats();
    repeat (3) @(posedge clk); #1;
    check("reset_outputs", {bus.rd_en, bus.rd_bank, bus.rd_addr, bus.out_valid, bus.out_data,
                            bus.busy, bus.done}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", {bus.rd_en, bus.out_valid, bus.busy, bus.done}, 0);

    for (int i = 0; i < 7; i++) run_event(tbl[i]);

    // reset while two reads are in flight
    salt = SALT_W'($urandom());
    build_model(put('0, 4, 20));
    @(posedge clk); #1;
    rdy_mode = 0;
    bus.nent_i = put('0, 4, 20);
    bus.start = 1'b1;
    reset_stats();
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reads_in_flight_before_reset", issued - popped, 2);
    check("rd_en_before_reset", bus.rd_en, 1);
    rst_n = 1'b0;
    #1;
    check("outputs_zero_in_reset", {bus.rd_en, bus.rd_bank, bus.rd_addr, bus.out_valid,
                                     bus.out_data, bus.busy, bus.done}, 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    reset_stats();
    repeat (8) @(negedge clk);
    check("no_done_after_reset", done_cnt, 0);
    check("no_words_after_reset", popped, 0);
    run_event(mkvec(put('0, 1, 1), 0, 1, 5, 6, -1, "after_reset_b1x1"));

    // random events against the queue model
    for (int e = 0; e < 6; e++) begin
      nent_t n;
      int sel, c, tot, rm;
      n = '0;
      tot = 0;
      for (int b = 0; b < NBANK; b++) begin
        sel = int'($urandom_range(0, 9));
        c = (sel < 3) ? int'($urandom_range(1, 6)) : (sel == 9) ? int'($urandom_range(60, 127)) : 0;
        n = put(n, b, c);
        tot += (c > 64) ? 64 : c;
      end
      rm = e % 3;
      run_event(mkvec(n, rm, tot, (tot > 0) ? 5 : -1,
                      (tot == 0) ? 3 : ((rm == 0) ? tot + 5 : -1), -1,
                      $sformatf("rand%0d", e)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
